// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and width helper for the synchronous FIFO
package fifo_pkg;
  localparam int DEFAULT_DSIZE = 140;
  localparam int DEFAULT_ASIZE = 2;

  function automatic int count_width(input int asize);
    return asize + 1;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DSIZE register array, sync write, async read
module fifo_mem #(
  parameter int DSIZE = 140,
  parameter int ASIZE = 2
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [ASIZE-1:0] waddr_i,
  input  logic [DSIZE-1:0] wdata_i,
  input  logic [ASIZE-1:0] raddr_i,
  output logic [DSIZE-1:0] rdata_o
);
  localparam int DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem_q [DEPTH];

  // Contents are deliberately never reset; occupancy alone defines validity.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/param_sync_fifo.sv
// rtl/param_sync_fifo.sv - parameterised single-clock FIFO with registered flags
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DSIZE    = DEFAULT_DSIZE,
  parameter int ASIZE    = DEFAULT_ASIZE,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = (1 << ASIZE) - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             fifo_clr,
  input  logic             fifo_w_enable,
  input  logic             fifo_r_enable,
  input  logic [DSIZE-1:0] data_to_fifo,
  output logic [DSIZE-1:0] data_from_fifo,
  output logic             fifo_empty,
  output logic             fifo_full,
  output logic             fifo_almost_empty,
  output logic             fifo_almost_full,
  output logic [ASIZE:0]   fifo_count,
  output logic             fifo_overflow,
  output logic             fifo_underflow
);
  localparam int CW    = count_width(ASIZE);
  localparam int DEPTH = 1 << ASIZE;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [ASIZE-1:0] wptr_q, wptr_d, rptr_q, rptr_d, raddr;
  logic [CW-1:0]    count_q, count_d;
  logic [DSIZE-1:0] dout_q, dout_d, rdata;
  logic             empty_q, empty_d, full_q, full_d;
  logic             ae_q, ae_d, af_q, af_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             wa, ra;

  always_comb begin
    ra = fifo_r_enable & ~empty_q & ~fifo_clr;
    wa = fifo_w_enable & (~full_q | ra) & ~fifo_clr;
    if (fifo_clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      wptr_d  = wptr_q + ASIZE'(wa);
      rptr_d  = rptr_q + ASIZE'(ra);
      count_d = count_q + CW'(wa) - CW'(ra);
      ovf_d   = ovf_q | (fifo_w_enable & full_q & ~ra);
      unf_d   = unf_q | (fifo_r_enable & empty_q);
    end
    // With count_d forced to zero on clear, these land on their reset values.
    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH_C);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);
  end

  // FWFT looks ahead at the next head; registered mode reads the current head.
  assign raddr = (FWFT != 0) ? rptr_d : rptr_q;

  always_comb begin
    dout_d = dout_q;
    if (FWFT != 0) begin
      if (!fifo_clr && count_d != '0) begin
        // Nothing left after this read: the head must be the word being written now.
        dout_d = (count_q == CW'(ra)) ? data_to_fifo : rdata;
      end
    end else if (ra) begin
      dout_d = rdata;
    end
  end

  fifo_mem #(
    .DSIZE(DSIZE),
    .ASIZE(ASIZE)
  ) u_mem (
    .clk_i  (clk_in),
    .we_i   (wa),
    .waddr_i(wptr_q),
    .wdata_i(data_to_fifo),
    .raddr_i(raddr),
    .rdata_o(rdata)
  );

  always_ff @(posedge clk_in) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ae_q    <= 1'b1;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ae_q    <= ae_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign data_from_fifo    = dout_q;
  assign fifo_empty        = empty_q;
  assign fifo_full         = full_q;
  assign fifo_almost_empty = ae_q;
  assign fifo_almost_full  = af_q;
  assign fifo_count        = count_q;
  assign fifo_overflow     = ovf_q;
  assign fifo_underflow    = unf_q;
endmodule

// File: tb/tb_param_sync_fifo.sv
// tb/tb_param_sync_fifo.sv - directed self-checking bench, registered and FWFT builds
module tb_param_sync_fifo;
  localparam int DW = 140;

  logic          clk = 1'b0;
  logic          rst, clr, wen, ren;
  logic [DW-1:0] din;

  logic [DW-1:0] dout, f_dout;
  logic          empty, full, ae, af, ovf, unf;
  logic          f_empty, f_full, f_ae, f_af, f_ovf, f_unf;
  logic [2:0]    cnt, f_cnt;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_v;

  always #5 clk = ~clk;

  param_sync_fifo #(.DSIZE(DW), .ASIZE(2), .FWFT(0), .AF_LEVEL(3), .AE_LEVEL(1)) u_dut (
    .clk_in(clk), .rst(rst), .fifo_clr(clr), .fifo_w_enable(wen), .fifo_r_enable(ren),
    .data_to_fifo(din), .data_from_fifo(dout), .fifo_empty(empty), .fifo_full(full),
    .fifo_almost_empty(ae), .fifo_almost_full(af), .fifo_count(cnt),
    .fifo_overflow(ovf), .fifo_underflow(unf)
  );

  param_sync_fifo #(.DSIZE(DW), .ASIZE(2), .FWFT(1), .AF_LEVEL(3), .AE_LEVEL(1)) u_dut_f (
    .clk_in(clk), .rst(rst), .fifo_clr(clr), .fifo_w_enable(wen), .fifo_r_enable(ren),
    .data_to_fifo(din), .data_from_fifo(f_dout), .fifo_empty(f_empty), .fifo_full(f_full),
    .fifo_almost_empty(f_ae), .fifo_almost_full(f_af), .fifo_count(f_cnt),
    .fifo_overflow(f_ovf), .fifo_underflow(f_unf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; wen = 1'b0; ren = 1'b0; din = '0;
    tick(); tick();
    if ({cnt, empty, ae, full, af, ovf, unf} !== {3'd0, 6'b110000}) begin
      errors++; $display("FAIL reset_flags: got cnt=%0d flags=%b required cnt=0 flags=110000",
                         cnt, {empty, ae, full, af, ovf, unf});
    end
    checks++;
    if (dout !== '0 || f_dout !== '0) begin
      errors++; $display("FAIL reset_dout: got %0h/%0h required 0/0", dout, f_dout);
    end
    checks++;
    rst = 1'b0;
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 4; i++) begin
      wen = 1'b1; din = DW'(i);
      tick();
      if (cnt !== 3'(i)) begin
        errors++; $display("FAIL fill_count: got %0d required %0d", cnt, i);
      end
      checks++;
      if (af !== (i >= 3) || full !== (i == 4) || empty !== 1'b0 || ae !== (i <= 1)) begin
        errors++; $display("FAIL fill_flags[%0d]: got af=%b full=%b empty=%b ae=%b", i, af, full, empty, ae);
      end
      checks++;
      if (f_dout !== DW'(1)) begin
        errors++; $display("FAIL fwft_head_fill: got %0h required 1", f_dout);
      end
      checks++;
    end
    wen = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      ren = 1'b1;
      tick();
      if (dout !== DW'(i)) begin
        errors++; $display("FAIL drain_data: got %0h required %0h", dout, i);
      end
      checks++;
      if (empty !== (i == 4) || cnt !== 3'(4 - i)) begin
        errors++; $display("FAIL drain_state[%0d]: got empty=%b cnt=%0d", i, empty, cnt);
      end
      checks++;
      if (f_dout !== DW'((i < 4) ? i + 1 : 4)) begin
        errors++; $display("FAIL fwft_head_drain[%0d]: got %0h", i, f_dout);
      end
      checks++;
    end
    ren = 1'b0;
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 4; i++) begin
      wen = 1'b1; din = DW'(i); tick();
    end
    din = DW'(5);
    tick();
    wen = 1'b0;
    if (ovf !== 1'b1 || cnt !== 3'd4 || full !== 1'b1) begin
      errors++; $display("FAIL overflow: got ovf=%b cnt=%0d full=%b required 1/4/1", ovf, cnt, full);
    end
    checks++;
    for (int i = 1; i <= 4; i++) begin
      ren = 1'b1; tick();
      if (dout !== DW'(i)) begin
        errors++; $display("FAIL overflow_drain: got %0h required %0h", dout, i);
      end
      checks++;
    end
    ren = 1'b0;
    tick();
    if (empty !== 1'b1) begin
      errors++; $display("FAIL overflow_empty: got %b required 1", empty);
    end
    checks++;
  endtask

  task automatic test_full_rw_wrap();
    for (int i = 1; i <= 4; i++) begin
      wen = 1'b1; din = DW'(i); exp_q.push_back(DW'(i)); tick();
    end
    for (int k = 0; k <= 10; k++) begin
      wen = 1'b1; ren = 1'b1;
      din = (k == 0) ? DW'(5) : DW'(16 + k - 1);
      exp_q.push_back(din);
      exp_v = exp_q.pop_front();
      tick();
      if (dout !== exp_v || cnt !== 3'd4 || full !== 1'b1) begin
        errors++; $display("FAIL full_rw[%0d]: got dout=%0h cnt=%0d full=%b required %0h/4/1",
                           k, dout, cnt, full, exp_v);
      end
      checks++;
    end
    wen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ren = 1'b1;
      exp_v = exp_q.pop_front();
      tick();
      if (dout !== exp_v) begin
        errors++; $display("FAIL wrap_drain: got %0h required %0h", dout, exp_v);
      end
      checks++;
    end
    ren = 1'b0;
  endtask

  task automatic test_underflow();
    clr = 1'b1; tick(); clr = 1'b0;
    if (ovf !== 1'b0 || unf !== 1'b0) begin
      errors++; $display("FAIL pre_underflow: got ovf=%b unf=%b required 0/0", ovf, unf);
    end
    checks++;
    wen = 1'b1; ren = 1'b1; din = DW'(10);
    tick();
    wen = 1'b0; ren = 1'b0;
    if (unf !== 1'b1 || cnt !== 3'd1 || empty !== 1'b0) begin
      errors++; $display("FAIL underflow: got unf=%b cnt=%0d empty=%b required 1/1/0", unf, cnt, empty);
    end
    checks++;
    if (dout !== DW'(25)) begin
      errors++; $display("FAIL underflow_hold: got %0h required 19", dout);
    end
    checks++;
    if (f_dout !== DW'(10) || f_unf !== 1'b1) begin
      errors++; $display("FAIL fwft_first_word: got %0h unf=%b required a/1", f_dout, f_unf);
    end
    checks++;
  endtask

  task automatic test_clear();
    for (int i = 11; i <= 14; i++) begin
      wen = 1'b1; din = DW'(i); tick();
    end
    wen = 1'b0; ren = 1'b1; tick(); ren = 1'b0;
    if (dout !== DW'(10) || cnt !== 3'd3 || ovf !== 1'b1) begin
      errors++; $display("FAIL pre_clear: got dout=%0h cnt=%0d ovf=%b required a/3/1", dout, cnt, ovf);
    end
    checks++;
    clr = 1'b1; wen = 1'b1; ren = 1'b1; din = DW'(15);
    tick();
    clr = 1'b0; wen = 1'b0; ren = 1'b0;
    if ({cnt, empty, ae, full, af, ovf, unf} !== {3'd0, 6'b110000}) begin
      errors++; $display("FAIL clear_state: got cnt=%0d flags=%b required cnt=0 flags=110000",
                         cnt, {empty, ae, full, af, ovf, unf});
    end
    checks++;
    if (dout !== DW'(10) || f_dout !== DW'(11)) begin
      errors++; $display("FAIL clear_dout: got %0h/%0h required a/b", dout, f_dout);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    wen = 1'b1; din = DW'(32); tick();
    din = DW'(33); tick();
    rst = 1'b1; din = DW'(34); tick();
    if ({cnt, empty, ae, full, af, ovf, unf} !== {3'd0, 6'b110000} || dout !== '0 || f_dout !== '0) begin
      errors++; $display("FAIL reset_mid: got cnt=%0d flags=%b dout=%0h/%0h required 0/110000/0/0",
                         cnt, {empty, ae, full, af, ovf, unf}, dout, f_dout);
    end
    checks++;
    rst = 1'b0; din = DW'(48); tick();
    wen = 1'b0; ren = 1'b1; tick(); ren = 1'b0;
    if (dout !== DW'(48) || empty !== 1'b1 || f_dout !== DW'(48)) begin
      errors++; $display("FAIL after_reset: got dout=%0h empty=%b fdout=%0h required 30/1/30",
                         dout, empty, f_dout);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_rw_wrap();
    test_underflow();
    test_clear();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter DSIZE, default 140, data word width in bits, SHALL be at least 1.
REQ-002 Parameter ASIZE, default 2, address width, SHALL be at least 1; depth is DEPTH = 2^ASIZE.
REQ-003 Parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-004 Parameter AF_LEVEL, default DEPTH-1, almost-full threshold, SHALL be in 1..DEPTH.
REQ-005 Parameter AE_LEVEL, default 1, almost-empty threshold, SHALL be in 0..DEPTH-1.
REQ-006 clk_in  input  1  sole clock; all state SHALL update on its rising edge.
REQ-007 rst  input  1  synchronous reset, active-high.
REQ-008 fifo_clr  input  1  synchronous flush request.
REQ-009 fifo_w_enable  input  1  write request.
REQ-010 fifo_r_enable  input  1  read request.
REQ-011 data_to_fifo  input  DSIZE  write data.
REQ-012 data_from_fifo  output  DSIZE  read data.
REQ-013 fifo_empty, fifo_full  output  1 each  occupancy 0, occupancy DEPTH.
REQ-014 fifo_almost_empty, fifo_almost_full  output  1 each  threshold flags.
REQ-015 fifo_count  output  ASIZE+1  current occupancy, 0..DEPTH.
REQ-016 fifo_overflow, fifo_underflow  output  1 each  sticky error flags.

Function
REQ-017 Write accepted (wa) SHALL equal fifo_w_enable AND (NOT fifo_full OR ra), with fifo_clr low.
REQ-018 Read accepted (ra) SHALL equal fifo_r_enable AND NOT fifo_empty, with fifo_clr low.
REQ-019 The next value of fifo_count SHALL be fifo_count + wa - ra. Simultaneous wa and ra SHALL leave the count unchanged.
REQ-020 Write and read pointers SHALL be ASIZE bits wide and wrap modulo DEPTH without any gap cycle.
REQ-021 All flags SHALL be registered and computed from the next count. Each flag SHALL be valid in the cycle after the access that changes it.
REQ-022 fifo_almost_full SHALL be 1 iff count >= AF_LEVEL. fifo_almost_empty SHALL be 1 iff count <= AE_LEVEL.
REQ-023 FWFT=0: on ra, data_from_fifo SHALL load the head word at that edge (1-cycle latency); otherwise it holds its value.
REQ-024 FWFT=1: data_from_fifo SHALL present the head word whenever fifo_empty=0. It SHALL hold its last value when empty. A word written into an empty FIFO SHALL appear one cycle after the write edge.
REQ-025 A write request while full without ra SHALL be dropped, set fifo_overflow, and leave the contents intact.
REQ-026 A read request while empty SHALL be ignored and set fifo_underflow; data_from_fifo holds its value.
REQ-027 When empty, a simultaneous read and write SHALL accept the write only and set fifo_underflow.
REQ-028 fifo_clr SHALL take priority over reads and writes. It SHALL zero both pointers and the count and set the flags to their reset values, and it SHALL clear fifo_overflow and fifo_underflow. data_from_fifo SHALL be unchanged.

Reset
REQ-029 rst SHALL take priority over fifo_clr and all requests.
REQ-030 On rst: pointers 0, fifo_count 0, fifo_empty 1, fifo_almost_empty 1, fifo_full 0, fifo_almost_full 0, fifo_overflow 0, fifo_underflow 0, data_from_fifo 0.
REQ-031 Storage contents SHALL NOT be reset.
REQ-032 Reset asserted mid-operation SHALL discard all stored words within one edge.

Structure
REQ-033 Shared package fifo_pkg SHALL hold the default DSIZE/ASIZE constants and a count-width helper (ASIZE+1).
REQ-034 Storage SHALL be one sub-module, fifo_mem: DEPTH x DSIZE register array with one synchronous write port and one asynchronous read port. The control logic, flags and output register SHALL stay in param_sync_fifo.

Verification (DSIZE=140, ASIZE=2, AF_LEVEL=3, AE_LEVEL=1 unless stated)
REQ-035 Fill/drain, FWFT=0: write 0x1..0x4 -> fifo_count 1,2,3,4, fifo_almost_full at count 3, fifo_full at 4. Then read 4 times -> data_from_fifo 0x1..0x4, each 1 cycle after its read, fifo_empty=1 after the last.
REQ-036 Overflow: with the FIFO full, write 0x5 without a read -> fifo_overflow=1, count stays 4, and the later reads return 0x1..0x4 (no 0x5).
REQ-037 Full plus simultaneous read and write of 0x5 -> count stays 4 and fifo_full stays 1. Wrap-around check: 10 such cycles followed by a drain -> output order preserved with no loss.
REQ-038 Empty plus simultaneous read and write of 0xA -> fifo_underflow=1, count=1. FWFT=1 build -> data_from_fifo=0xA one cycle after the write.
REQ-039 fifo_clr with count=3 and fifo_overflow=1 -> next cycle count 0, fifo_empty=1, fifo_overflow=0. rst asserted during continuous writes -> all outputs at REQ-030 values on the next edge.
